// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: a Moore FSM that sequences
// fetch/decode/execute/mem/writeback over one shared memory port.
// Every memory access has a wait-state handshake and a timeout.
//
// Memory handshake, for any request state (FETCH, MEMRD, MEMWR):
//   - mem_req stays high, with stable iord/mem_write, until the cycle in
//     which mem_ready=1. That cycle completes the access.
//   - mem_ready is ignored while mem_req=0.
//   - After MAX_WAIT consecutive not-ready cycles, bus_err pulses, the
//     access is abandoned without any commit, and the FSM returns to FETCH.
module mc_controller #(
    parameter int ALU_CTRL_W = 3,
    parameter int EN_ADDI    = 1,
    parameter int EN_JMP     = 1,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            op,
    input  logic [5:0]            funct,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic                  iord,
    output logic                  ir_write,
    output logic                  pc_en,
    output logic                  reg_write,
    output logic                  reg_dst,
    output logic                  mem_to_reg,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            pc_src,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  illegal,
    output logic                  bus_err,
    output logic [3:0]            state_o
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam int CW = $clog2(MAX_WAIT + 1);

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(3'b010);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(3'b110);
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(3'b000);
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(3'b001);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(3'b111);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t         r_state;
    state_t         w_next;
    logic [CW-1:0]  r_wait;
    logic [CW-1:0]  w_wait_next;
    logic           w_req_state;
    logic           w_timeout;

    assign state_o = r_state;

    // A request state is one that holds mem_req; the timeout fires when this
    // not-ready cycle would bring the wait count up to MAX_WAIT.
    always_comb begin
        w_req_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
        w_timeout   = w_req_state && !mem_ready && (r_wait >= CW'(MAX_WAIT - 1));
    end

    // Wait counter: counts stalled request cycles, clears whenever the
    // access completes or is abandoned, and saturates rather than wrapping.
    always_comb begin
        w_wait_next = '0;
        if (w_req_state && !mem_ready && !w_timeout) begin
            w_wait_next = (r_wait == CW'(MAX_WAIT)) ? r_wait : r_wait + CW'(1);
        end
    end

    // State and wait-counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_next;
        end
    end

    // Next-state and output decode; reset forces every output to 0.
    always_comb begin
        w_next     = r_state;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_ctrl   = '0;
        illegal    = 1'b0;
        bus_err    = 1'b0;

        case (r_state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                alu_ctrl  = ALU_ADD;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_en    = 1'b1;
                    w_next   = S_DECODE;
                end else if (w_timeout) begin
                    bus_err = 1'b1;
                    w_next  = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_ctrl  = ALU_ADD;
                if (op == OP_LW || op == OP_SW) begin
                    w_next = S_MEMADR;
                end else if (op == OP_RTYPE) begin
                    w_next = S_RTYPEEX;
                end else if (op == OP_BEQ) begin
                    w_next = S_BEQEX;
                end else if (op == OP_ADDI && EN_ADDI != 0) begin
                    w_next = S_ADDIEX;
                end else if (op == OP_J && EN_JMP != 0) begin
                    w_next = S_JEX;
                end else begin
                    illegal = 1'b1;
                    w_next  = S_FETCH;
                end
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                w_next    = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    w_next = S_MEMWB;
                end else if (w_timeout) begin
                    bus_err = 1'b1;
                    w_next  = S_FETCH;
                end
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    w_next = S_FETCH;
                end else if (w_timeout) begin
                    bus_err = 1'b1;
                    w_next  = S_FETCH;
                end
            end
            S_RTYPEEX: begin
                alu_src_a = 1'b1;
                w_next    = S_RTYPEWB;
                case (funct)
                    6'b100000: alu_ctrl = ALU_ADD;
                    6'b100010: alu_ctrl = ALU_SUB;
                    6'b100100: alu_ctrl = ALU_AND;
                    6'b100101: alu_ctrl = ALU_OR;
                    6'b101010: alu_ctrl = ALU_SLT;
                    default: begin
                        alu_ctrl = ALU_ADD;
                        illegal  = 1'b1;
                        w_next   = S_FETCH;
                    end
                endcase
            end
            S_RTYPEWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                w_next    = S_FETCH;
            end
            S_BEQEX: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ALU_SUB;
                pc_src    = 2'b01;
                pc_en     = zero;
                w_next    = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                w_next    = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                w_next    = S_FETCH;
            end
            S_JEX: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
                w_next = S_FETCH;
            end
            default: begin
                illegal = 1'b1;
                w_next  = S_FETCH;
            end
        endcase

        if (reset) begin
            w_next     = S_FETCH;
            mem_req    = 1'b0;
            mem_write  = 1'b0;
            iord       = 1'b0;
            ir_write   = 1'b0;
            pc_en      = 1'b0;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            pc_src     = 2'b00;
            alu_ctrl   = '0;
            illegal    = 1'b0;
            bus_err    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed testbench for mc_controller: one task per scenario, each with
// inline comparisons against hand-computed values.
module tb_mc_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_ctrl;
    logic       illegal;
    logic       bus_err;
    logic [3:0] state_o;

    int n_cmp;
    int n_err;

    mc_controller #(
        .ALU_CTRL_W(3),
        .EN_ADDI   (1),
        .EN_JMP    (1),
        .MAX_WAIT  (15)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_write (mem_write),
        .iord      (iord),
        .ir_write  (ir_write),
        .pc_en     (pc_en),
        .reg_write (reg_write),
        .reg_dst   (reg_dst),
        .mem_to_reg(mem_to_reg),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .pc_src    (pc_src),
        .alu_ctrl  (alu_ctrl),
        .illegal   (illegal),
        .bus_err   (bus_err),
        .state_o   (state_o)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and step just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle reset pulse; leaves the DUT in FETCH.
    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'b0;
        zero      = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] ctl;
        reset     = 1'b1;
        mem_ready = 1'b1;
        op        = 6'b100011;
        funct     = 6'b000000;
        zero      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            ctl = {mem_req, ir_write, pc_en, reg_write, illegal, bus_err};
            n_cmp++;
            if (ctl !== 6'b0) begin
                n_err++;
                $display("FAIL reset_outputs cyc%0d: got %b want 000000", i, ctl);
            end
            tick();
        end
        n_cmp++;
        if (state_o !== 4'd0) begin
            n_err++;
            $display("FAIL reset_state: got %0d want 0", state_o);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({state_o, ir_write, pc_en} !== {4'd0, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL release_fetch: state %0d ir_write %b pc_en %b want 0 1 1", state_o, ir_write, pc_en);
        end
        tick();
        n_cmp++;
        if ({state_o, ir_write, pc_en} !== {4'd1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL release_decode: state %0d ir_write %b pc_en %b want 1 0 0", state_o, ir_write, pc_en);
        end
    endtask

    task automatic test_lw();
        logic [3:0] exp_st [0:5];
        int wb;
        exp_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        wb = 0;
        do_reset();
        op        = 6'b100011;
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_cmp++;
            if (state_o !== exp_st[i]) begin
                n_err++;
                $display("FAIL lw_state cyc%0d: got %0d want %0d", i, state_o, exp_st[i]);
            end
            if (state_o == 4'd3) begin
                n_cmp++;
                if ({mem_req, iord, mem_write} !== 3'b110) begin
                    n_err++;
                    $display("FAIL lw_memrd_ctl: got %b want 110", {mem_req, iord, mem_write});
                end
            end
            if (reg_write && mem_to_reg) wb++;
            if (i < 5) tick();
        end
        n_cmp++;
        if (wb !== 1) begin
            n_err++;
            $display("FAIL lw_writeback_count: got %0d want 1", wb);
        end
    endtask

    task automatic test_sw();
        int wr_cycles;
        int rw_cycles;
        wr_cycles = 0;
        rw_cycles = 0;
        do_reset();
        op = 6'b101011;
        for (int i = 0; i < 7; i++) begin
            mem_ready = (i >= 3 && i <= 5) ? 1'b0 : 1'b1;
            #1;
            if (mem_req && mem_write) wr_cycles++;
            if (reg_write) rw_cycles++;
            tick();
        end
        n_cmp++;
        if (wr_cycles !== 4) begin
            n_err++;
            $display("FAIL sw_write_cycles: got %0d want 4", wr_cycles);
        end
        n_cmp++;
        if (rw_cycles !== 0) begin
            n_err++;
            $display("FAIL sw_reg_write: got %0d want 0", rw_cycles);
        end
        n_cmp++;
        if (state_o !== 4'd0) begin
            n_err++;
            $display("FAIL sw_end_state: got %0d want 0", state_o);
        end
    endtask

    task automatic test_beq(input logic z);
        do_reset();
        op        = 6'b000100;
        mem_ready = 1'b1;
        zero      = z;
        tick();
        tick();
        n_cmp++;
        if ({state_o, pc_en, pc_src, alu_ctrl} !== {4'd8, z, 2'b01, 3'b110}) begin
            n_err++;
            $display("FAIL beq_z%0b: state %0d pc_en %b pc_src %b alu %b want 8 %b 01 110",
                     z, state_o, pc_en, pc_src, alu_ctrl, z);
        end
        tick();
        n_cmp++;
        if (state_o !== 4'd0) begin
            n_err++;
            $display("FAIL beq_next_z%0b: got %0d want 0", z, state_o);
        end
    endtask

    task automatic test_rtype();
        do_reset();
        op        = 6'b000000;
        funct     = 6'b101010;
        mem_ready = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({state_o, alu_src_a, alu_src_b, alu_ctrl} !== {4'd6, 1'b1, 2'b00, 3'b111}) begin
            n_err++;
            $display("FAIL rtype_ex: state %0d src_a %b src_b %b alu %b want 6 1 00 111",
                     state_o, alu_src_a, alu_src_b, alu_ctrl);
        end
        tick();
        n_cmp++;
        if ({state_o, reg_write, reg_dst, mem_to_reg} !== {4'd7, 1'b1, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL rtype_wb: state %0d rw %b dst %b m2r %b want 7 1 1 0",
                     state_o, reg_write, reg_dst, mem_to_reg);
        end
        tick();
        n_cmp++;
        if (state_o !== 4'd0) begin
            n_err++;
            $display("FAIL rtype_next: got %0d want 0", state_o);
        end
    endtask

    task automatic test_addi_jmp();
        do_reset();
        op        = 6'b001000;
        mem_ready = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({state_o, alu_src_a, alu_src_b, alu_ctrl} !== {4'd9, 1'b1, 2'b10, 3'b010}) begin
            n_err++;
            $display("FAIL addi_ex: state %0d src_a %b src_b %b alu %b want 9 1 10 010",
                     state_o, alu_src_a, alu_src_b, alu_ctrl);
        end
        tick();
        n_cmp++;
        if ({state_o, reg_write, reg_dst, mem_to_reg} !== {4'd10, 1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL addi_wb: state %0d rw %b dst %b m2r %b want 10 1 0 0",
                     state_o, reg_write, reg_dst, mem_to_reg);
        end
        tick();
        op = 6'b000010;
        tick();
        tick();
        n_cmp++;
        if ({state_o, pc_en, pc_src} !== {4'd11, 1'b1, 2'b10}) begin
            n_err++;
            $display("FAIL jmp_ex: state %0d pc_en %b pc_src %b want 11 1 10", state_o, pc_en, pc_src);
        end
        tick();
        n_cmp++;
        if (state_o !== 4'd0) begin
            n_err++;
            $display("FAIL jmp_next: got %0d want 0", state_o);
        end
    endtask

    task automatic test_illegal();
        int pulses;
        do_reset();
        mem_ready = 1'b1;
        op        = 6'b111111;
        pulses    = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            if (illegal) pulses++;
            tick();
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_err++;
            $display("FAIL illegal_op_pulses: got %0d want 1", pulses);
        end
        n_cmp++;
        if ({state_o, reg_write} !== {4'd0, 1'b0}) begin
            n_err++;
            $display("FAIL illegal_op_next: state %0d rw %b want 0 0", state_o, reg_write);
        end
        op     = 6'b000000;
        funct  = 6'b000001;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (illegal) pulses++;
            tick();
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_err++;
            $display("FAIL illegal_funct_pulses: got %0d want 1", pulses);
        end
        n_cmp++;
        if ({state_o, reg_write} !== {4'd0, 1'b0}) begin
            n_err++;
            $display("FAIL illegal_funct_next: state %0d rw %b want 0 0", state_o, reg_write);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        op        = 6'b100011;
        mem_ready = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            #1;
            n_cmp++;
            if ({state_o, bus_err, ir_write, pc_en} !== {4'd0, (k == 15), 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL timeout_wait%0d: state %0d bus_err %b ir_write %b pc_en %b want 0 %b 0 0",
                         k, state_o, bus_err, ir_write, pc_en, (k == 15));
            end
            tick();
        end
        n_cmp++;
        if ({state_o, bus_err, mem_req} !== {4'd0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL timeout_restart: state %0d bus_err %b mem_req %b want 0 0 1", state_o, bus_err, mem_req);
        end
        mem_ready = 1'b1;
        #1;
        n_cmp++;
        if ({ir_write, pc_en} !== 2'b11) begin
            n_err++;
            $display("FAIL timeout_recover: got %b want 11", {ir_write, pc_en});
        end
        tick();
        n_cmp++;
        if (state_o !== 4'd1) begin
            n_err++;
            $display("FAIL timeout_recover_state: got %0d want 1", state_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        op        = 6'b100011;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        n_cmp++;
        if (state_o !== 4'd4) begin
            n_err++;
            $display("FAIL mid_reach_memwb: got %0d want 4", state_o);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (reg_write !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_rw: got %b want 0", reg_write);
        end
        tick();
        reset = 1'b0;
        #1;
        n_cmp++;
        if (state_o !== 4'd0) begin
            n_err++;
            $display("FAIL mid_reset_state: got %0d want 0", state_o);
        end
        tick();
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        op        = 6'b0;
        funct     = 6'b0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        test_reset();
        test_lw();
        test_sw();
        test_beq(1'b1);
        test_beq(1'b0);
        test_rtype();
        test_addi_jmp();
        test_illegal();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
